// File: rtl/div_operand_join_if.sv
// Valid/ready data stream between pipeline stages.
interface div_operand_join_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport consumer (input valid, input data, output ready);
    modport producer (output valid, output data, input ready);
endinterface

// File: rtl/div_operand_join.sv
// Pairs dividend/divisor streams, screens zero divisors, feeds divider operands.
// Latency: 2 cycles from joint accept to dout (hold stage + output stage).
// Backpressure: holds one output pair plus one operand per input; din ready drops when full.
module div_operand_join #(
    parameter int W0        = 16,
    parameter int W1        = 16,
    parameter int ZERO_DROP = 1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    div_operand_join_if.consumer din0,
    div_operand_join_if.consumer din1,
    div_operand_join_if.producer dout0,
    div_operand_join_if.producer dout1,
    output logic                 zero_err,
    output logic [CNT_W-1:0]     zero_cnt
);
    localparam bit DROP = (ZERO_DROP != 0);

    logic [W0-1:0] h0, o0;
    logic [W1-1:0] h1, o1;
    logic          h0_v, h1_v, o_v;
    logic          acc0, acc1, take, move, z, fwd;

    assign take = o_v & dout0.ready & dout1.ready;
    assign move = h0_v & h1_v & (!o_v | take);
    assign z    = (h1 == '0);
    // A dropped pair leaves the output stage as it was (or empty after take).
    assign fwd  = move & !(z & DROP);

    assign din0.ready = !h0_v | move;
    assign din1.ready = !h1_v | move;
    assign acc0       = din0.valid & din0.ready;
    assign acc1       = din1.valid & din1.ready;

    assign dout0.valid = o_v;
    assign dout1.valid = o_v;
    assign dout0.data  = o0;
    assign dout1.data  = o1;

    always_ff @(posedge clk) begin
        if (rst) begin
            h0_v     <= 1'b0;
            h1_v     <= 1'b0;
            o_v      <= 1'b0;
            zero_err <= 1'b0;
            zero_cnt <= '0;
        end else begin
            if (acc0)
                h0_v <= 1'b1;
            else if (move)
                h0_v <= 1'b0;

            if (acc1)
                h1_v <= 1'b1;
            else if (move)
                h1_v <= 1'b0;

            if (fwd)
                o_v <= 1'b1;
            else if (take)
                o_v <= 1'b0;

            zero_err <= move & z;
            if (move && z && (zero_cnt != '1))
                zero_cnt <= zero_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (acc0)
            h0 <= din0.data;
        if (acc1)
            h1 <= din1.data;
        if (fwd) begin
            o0 <= h0;
            o1 <= h1;
        end
    end
endmodule

// File: tb/tb_div_operand_join.sv
// Directed table plus hand sequences for div_operand_join (drop, forward, saturation, reset).
module tb_div_operand_join;
    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, ro0, ro1;
    logic [15:0] d0, d1;

    always #5 clk = ~clk;

    // a: defaults, b: zero divisors forwarded, c: 2-bit counter
    div_operand_join_if #(.W(16)) a_i0(), a_i1(), a_o0(), a_o1();
    div_operand_join_if #(.W(16)) b_i0(), b_i1(), b_o0(), b_o1();
    div_operand_join_if #(.W(16)) c_i0(), c_i1(), c_o0(), c_o1();
    logic       a_err, b_err, c_err;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;

    assign a_i0.valid = v0;  assign a_i0.data = d0;  assign a_i1.valid = v1;  assign a_i1.data = d1;
    assign b_i0.valid = v0;  assign b_i0.data = d0;  assign b_i1.valid = v1;  assign b_i1.data = d1;
    assign c_i0.valid = v0;  assign c_i0.data = d0;  assign c_i1.valid = v1;  assign c_i1.data = d1;
    assign a_o0.ready = ro0; assign a_o1.ready = ro1;
    assign b_o0.ready = ro0; assign b_o1.ready = ro1;
    assign c_o0.ready = ro0; assign c_o1.ready = ro1;

    div_operand_join #(.W0(16), .W1(16), .ZERO_DROP(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din0(a_i0), .din1(a_i1), .dout0(a_o0), .dout1(a_o1),
        .zero_err(a_err), .zero_cnt(a_cnt));
    div_operand_join #(.W0(16), .W1(16), .ZERO_DROP(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .din0(b_i0), .din1(b_i1), .dout0(b_o0), .dout1(b_o1),
        .zero_err(b_err), .zero_cnt(b_cnt));
    div_operand_join #(.W0(16), .W1(16), .ZERO_DROP(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .din0(c_i0), .din1(c_i1), .dout0(c_o0), .dout1(c_o1),
        .zero_err(c_err), .zero_cnt(c_cnt));

    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        logic        ro0, ro1;
        logic        er0, er1, eov;
        logic [15:0] eo0, eo1;
        logic        ezerr;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic void add(input int iv0, input int id0, input int iv1, input int id1,
                                input int iro0, input int iro1, input int er0, input int er1,
                                input int eov, input int eo0, input int eo1,
                                input int ezerr, input int ecnt);
        vec_t t;
        t.v0 = 1'(iv0);   t.d0 = 16'(id0);  t.v1 = 1'(iv1);   t.d1 = 16'(id1);
        t.ro0 = 1'(iro0); t.ro1 = 1'(iro1);
        t.er0 = 1'(er0);  t.er1 = 1'(er1);  t.eov = 1'(eov);
        t.eo0 = 16'(eo0); t.eo1 = 16'(eo1);
        t.ezerr = 1'(ezerr); t.ecnt = 8'(ecnt);
        tbl.push_back(t);
    endfunction

    task automatic drive(input int iv0, input int id0, input int iv1, input int id1);
        v0 = 1'(iv0); d0 = 16'(id0); v1 = 1'(iv1); d1 = 16'(id1);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic ok;
        v0 = t.v0; d0 = t.d0; v1 = t.v1; d1 = t.d1; ro0 = t.ro0; ro1 = t.ro1;
        #1;
        ok = (a_i0.ready === t.er0) && (a_i1.ready === t.er1) && (a_o0.valid === t.eov)
             && (a_o1.valid === t.eov) && (a_err === t.ezerr) && (a_cnt === t.ecnt)
             && (!t.eov || ((a_o0.data === t.eo0) && (a_o1.data === t.eo1)));
        nvec++;
        if (!ok) begin
            nbad++;
            $display("FAIL vec %0d: got rdy=%b%b v=%b%b d=%0d/%0d err=%b cnt=%0d, want rdy=%b%b v=%b d=%0d/%0d err=%b cnt=%0d",
                     idx, a_i0.ready, a_i1.ready, a_o0.valid, a_o1.valid, a_o0.data, a_o1.data,
                     a_err, a_cnt, t.er0, t.er1, t.eov, t.eo0, t.eo1, t.ezerr, t.ecnt);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        ro0 = 1'b1; ro1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int expc[6];
        bit seen;
        expc = '{1, 2, 3, 3, 3, 3};

        // pairs 100/7 and 50/5 with dout always ready
        add(1,100,1,7, 1,1, 1,1,0,0,0,0,0);
        add(1,50,1,5,  1,1, 1,1,0,0,0,0,0);
        add(0,0,0,0,   1,1, 1,1,1,100,7,0,0);
        add(0,0,0,0,   1,1, 1,1,1,50,5,0,0);
        add(0,0,0,0,   1,1, 1,1,0,0,0,0,0);
        // dividend waits five cycles for its divisor
        add(1,40,0,0,  1,1, 1,1,0,0,0,0,0);
        for (int i = 0; i < 4; i++) add(1,41,0,0, 1,1, 0,1,0,0,0,0,0);
        add(1,41,1,8,  1,1, 0,1,0,0,0,0,0);
        add(1,41,0,0,  1,1, 1,1,0,0,0,0,0);
        add(0,0,1,2,   1,1, 0,1,1,40,8,0,0);
        add(0,0,0,0,   1,1, 1,1,0,0,0,0,0);
        add(0,0,0,0,   1,1, 1,1,1,41,2,0,0);
        add(0,0,0,0,   1,1, 1,1,0,0,0,0,0);
        // zero divisor dropped
        add(1,9,1,0,   1,1, 1,1,0,0,0,0,0);
        add(1,12,1,3,  1,1, 1,1,0,0,0,0,0);
        add(0,0,0,0,   1,1, 1,1,0,0,0,1,1);
        add(0,0,0,0,   1,1, 1,1,1,12,3,0,1);
        add(0,0,0,0,   1,1, 1,1,0,0,0,0,1);
        // ten cycles of output stall, including single-ready cycles
        add(1,1,1,11,  0,0, 1,1,0,0,0,0,1);
        add(1,2,1,12,  0,0, 1,1,0,0,0,0,1);
        for (int c = 2; c < 10; c++)
            add(1,3,1,13, int'(c == 5 || c == 6), int'(c == 7), 0,0,1,1,11,0,1);
        add(1,3,1,13,  1,1, 1,1,1,1,11,0,1);
        add(0,0,0,0,   1,1, 1,1,1,2,12,0,1);
        add(0,0,0,0,   1,1, 1,1,1,3,13,0,1);
        add(0,0,0,0,   1,1, 1,1,0,0,0,0,1);

        rst = 1'b1;
        drive(0, 0, 0, 0);
        ro0 = 1'b1; ro1 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_b_valid", 32'(b_o0.valid), 0);
        chk("rst_c_cnt", 32'(c_cnt), 0);
        chk("rst_c_err", 32'(c_err), 0);

        foreach (tbl[i]) apply(tbl[i], i);

        // reset while output and both holds are full
        ro0 = 1'b0; ro1 = 1'b0;
        drive(1, 5, 1, 50); @(negedge clk);
        drive(1, 6, 1, 60); @(negedge clk);
        drive(1, 7, 1, 70); #1;
        chk("full_valid", 32'(a_o0.valid), 1);
        chk("full_rdy0", 32'(a_i0.ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        ro0 = 1'b1; ro1 = 1'b1;
        #1;
        chk("post_rst_valid", 32'(a_o0.valid), 0);
        chk("post_rst_rdy0", 32'(a_i0.ready), 1);
        chk("post_rst_rdy1", 32'(a_i1.ready), 1);
        chk("post_rst_cnt", 32'(a_cnt), 0);
        chk("post_rst_err", 32'(a_err), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(a_o0.valid), 0);
        end
        drive(1, 20, 1, 4);
        @(negedge clk);
        drive(0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (a_o0.valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("fresh_seen", 32'(seen), 1);
        chk("fresh_d0", 32'(a_o0.data), 20);
        chk("fresh_d1", 32'(a_o1.data), 4);

        // zero divisor forwarded when dropping is disabled
        do_reset();
        drive(1, 9, 1, 0);  @(negedge clk);
        drive(1, 12, 1, 3); @(negedge clk);
        drive(0, 0, 0, 0);  #1;
        chk("fwd_valid", 32'(b_o0.valid), 1);
        chk("fwd_d0", 32'(b_o0.data), 9);
        chk("fwd_d1", 32'(b_o1.data), 0);
        chk("fwd_err", 32'(b_err), 1);
        chk("fwd_cnt", 32'(b_cnt), 1);
        @(negedge clk);
        chk("fwd2_d0", 32'(b_o0.data), 12);
        chk("fwd2_d1", 32'(b_o1.data), 3);
        chk("fwd2_err", 32'(b_err), 0);
        chk("fwd2_cnt", 32'(b_cnt), 1);

        // 2-bit counter saturates
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive(1, c + 1, 1, 0);
            else       drive(0, 0, 0, 0);
            #1;
            if (c >= 2) begin
                chk("sat_cnt", 32'(c_cnt), expc[c-2]);
                chk("sat_err", 32'(c_err), 1);
                chk("sat_valid", 32'(c_o0.valid), 0);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
